// File: rtl/arp_tx.sv
// ARP request/reply frame generator driving an 8-bit GMII transmit port.
// Optional macro ARP_TX_PEND_EN adds a one-entry pending slot for strobes seen while busy.
module arp_tx #(
  parameter logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP   = 32'hC0_A8_01_0A,
  parameter int          IFG_CYCLES = 12
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic        arp_tx_en,
  input  logic        arp_tx_type,
  input  logic [47:0] des_mac,
  input  logic [31:0] des_ip,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd,
  output logic        tx_busy,
  output logic        tx_done,
  output logic [2:0]  dbg_state
);

  // Start handshake: arp_tx_en is a one-cycle strobe with no ready; it is accepted
  // only in IDLE (or into the pending slot when enabled), and type/MAC/IP are
  // sampled on the same edge and never re-read during the frame.
  typedef enum logic [2:0] {IDLE, PREAMBLE, ETH_HDR, ARP_DATA, PAD, FCS, IFG} state_t;

  localparam logic [6:0] IFG_LAST = 7'(IFG_CYCLES - 1);

  state_t      state, state_nxt;
  logic [6:0]  cnt, cnt_nxt;
  logic        load_in;
  logic        type_q;
  logic [47:0] mac_q;
  logic [31:0] ip_q;
  logic [7:0]  byte_val;
  logic        byte_crc;
  logic [31:0] crc_q, crc_nxt, fcs_sh;

`ifdef ARP_TX_PEND_EN
  logic        load_pend;
  logic        pend_valid;
  logic        pend_type;
  logic [47:0] pend_mac;
  logic [31:0] pend_ip;
`endif

  function automatic logic [7:0] sel48(input logic [47:0] v, input logic [6:0] i);
    logic [47:0] t;
    t = v << {i, 3'b000};
    return t[47:40];
  endfunction

  function automatic logic [7:0] sel32(input logic [31:0] v, input logic [6:0] i);
    logic [31:0] t;
    t = v << {i, 3'b000};
    return t[31:24];
  endfunction

  // Reflected CRC-32, one byte per call, LSB of the byte first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  assign dbg_state = state;
  assign fcs_sh    = (~crc_q) >> {cnt[1:0], 3'b000};
  assign crc_nxt   = crc_byte(crc_q, byte_val);

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
      cnt   <= 7'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 7'd1;
    load_in   = 1'b0;
`ifdef ARP_TX_PEND_EN
    load_pend = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_nxt = 7'd0;
        if (arp_tx_en) begin
          load_in   = 1'b1;
          state_nxt = PREAMBLE;
        end
`ifdef ARP_TX_PEND_EN
        else if (pend_valid) begin
          load_pend = 1'b1;
          state_nxt = PREAMBLE;
        end
`endif
      end
      PREAMBLE: if (cnt == 7'd7)  begin state_nxt = ETH_HDR;  cnt_nxt = 7'd0; end
      ETH_HDR:  if (cnt == 7'd13) begin state_nxt = ARP_DATA; cnt_nxt = 7'd0; end
      ARP_DATA: if (cnt == 7'd27) begin state_nxt = PAD;      cnt_nxt = 7'd0; end
      PAD:      if (cnt == 7'd17) begin state_nxt = FCS;      cnt_nxt = 7'd0; end
      FCS:      if (cnt == 7'd3)  begin state_nxt = IFG;      cnt_nxt = 7'd0; end
      IFG: begin
        if (cnt == IFG_LAST) begin
          cnt_nxt   = 7'd0;
          state_nxt = IDLE;
`ifdef ARP_TX_PEND_EN
          if (pend_valid) begin
            state_nxt = PREAMBLE;
            load_pend = 1'b1;
          end
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 7'd0;
      end
    endcase
  end

  // Byte to place on the wire next, and whether it is covered by the FCS.
  always_comb begin
    byte_val = 8'h00;
    byte_crc = 1'b0;
    case (state)
      PREAMBLE: byte_val = (cnt == 7'd7) ? 8'hD5 : 8'h55;
      ETH_HDR: begin
        byte_crc = 1'b1;
        if (cnt < 7'd6)       byte_val = type_q ? sel48(mac_q, cnt) : 8'hFF;
        else if (cnt < 7'd12) byte_val = sel48(BOARD_MAC, 7'(cnt - 7'd6));
        else if (cnt == 7'd12) byte_val = 8'h08;
        else                  byte_val = 8'h06;
      end
      ARP_DATA: begin
        byte_crc = 1'b1;
        if (cnt == 7'd1)       byte_val = 8'h01;
        else if (cnt == 7'd2)  byte_val = 8'h08;
        else if (cnt == 7'd4)  byte_val = 8'h06;
        else if (cnt == 7'd5)  byte_val = 8'h04;
        else if (cnt == 7'd7)  byte_val = type_q ? 8'h02 : 8'h01;
        else if (cnt >= 7'd8  && cnt <= 7'd13) byte_val = sel48(BOARD_MAC, 7'(cnt - 7'd8));
        else if (cnt >= 7'd14 && cnt <= 7'd17) byte_val = sel32(BOARD_IP, 7'(cnt - 7'd14));
        else if (cnt >= 7'd18 && cnt <= 7'd23) byte_val = type_q ? sel48(mac_q, 7'(cnt - 7'd18)) : 8'h00;
        else if (cnt >= 7'd24) byte_val = sel32(ip_q, 7'(cnt - 7'd24));
      end
      PAD:     byte_crc = 1'b1;
      FCS:     byte_val = fcs_sh[7:0];
      default: byte_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      gmii_tx_en <= 1'b0;
      gmii_txd   <= 8'h00;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      crc_q      <= 32'hFFFF_FFFF;
    end else begin
      gmii_tx_en <= (state != IDLE) && (state != IFG);
      gmii_txd   <= byte_val;
      tx_busy    <= (state != IDLE);
      tx_done    <= (state == IFG) && (cnt == 7'd0);
      if (state == IDLE || state == PREAMBLE) crc_q <= 32'hFFFF_FFFF;
      else if (byte_crc)                      crc_q <= crc_nxt;
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      type_q <= 1'b0;
      mac_q  <= 48'h0;
      ip_q   <= 32'h0;
    end else if (load_in) begin
      type_q <= arp_tx_type;
      mac_q  <= des_mac;
      ip_q   <= des_ip;
    end
`ifdef ARP_TX_PEND_EN
    else if (load_pend) begin
      type_q <= pend_type;
      mac_q  <= pend_mac;
      ip_q   <= pend_ip;
    end
`endif
  end

`ifdef ARP_TX_PEND_EN
  // A strobe while busy always wins over clearing, so one arriving on the IFG exit survives.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      pend_valid <= 1'b0;
      pend_type  <= 1'b0;
      pend_mac   <= 48'h0;
      pend_ip    <= 32'h0;
    end else if (arp_tx_en && state != IDLE) begin
      pend_valid <= 1'b1;
      pend_type  <= arp_tx_type;
      pend_mac   <= des_mac;
      pend_ip    <= des_ip;
    end else if (load_pend || load_in) begin
      pend_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/arp_tx.md
# arp_tx

Builds and serialises a complete Ethernet/ARP frame onto the 8-bit GMII transmit interface, one byte per `clk`. It is the consumer of the `arp_tx_en` / `arp_tx_type` strobe pair issued by the ARP control logic. It sits between that control logic and the GMII TX mux. It generates the preamble, Ethernet header, the 28-byte ARP payload, zero padding and CRC-32 FCS internally, then enforces an inter-frame gap.

## Interface
Parameters:
- `BOARD_MAC`, default 48'h00_11_22_33_44_55: source MAC and ARP sender MAC.
- `BOARD_IP`, default 32'hC0_A8_01_0A (192.168.1.10): ARP sender IP.
- `IFG_CYCLES`, default 12: idle cycles after the FCS before the next frame may start.

Ports:
- `clk` in 1: clock; all logic is on the rising edge.
- `sys_rst` in 1: reset, asynchronous, active-high.
- `arp_tx_en` in 1: one-cycle start strobe.
- `arp_tx_type` in 1: 0 = request, 1 = reply.
- `des_mac` in 48: peer MAC, used for a reply.
- `des_ip` in 32: target IP.
- `gmii_tx_en` out 1: GMII transmit enable.
- `gmii_txd` out 8: GMII transmit data.
- `tx_busy` out 1: high from the first frame byte through the end of the IFG.
- `tx_done` out 1: one-cycle pulse after the last FCS byte.

## Operation
- States: IDLE, PREAMBLE, ETH_HDR, ARP_DATA, PAD, FCS, IFG.
- In IDLE, `arp_tx_en`=1 captures `arp_tx_type`, `des_mac` and `des_ip` into registers, then the block enters PREAMBLE. Inputs are not resampled during the frame.
- PREAMBLE (8 bytes): 0x55 ×7, then 0xD5.
- ETH_HDR (14 bytes):
  - Destination MAC: FF:FF:FF:FF:FF:FF for a request, `des_mac` for a reply.
  - Source MAC: `BOARD_MAC`.
  - Type: 0x08 0x06.
- ARP_DATA (28 bytes, multi-byte fields MSB first):
  - 00 01 08 00 06 04
  - Opcode: 00 01 for a request, 00 02 for a reply.
  - `BOARD_MAC`, `BOARD_IP`.
  - Target MAC: all zero for a request, `des_mac` for a reply.
  - `des_ip`.
- PAD: 18 bytes of 0x00. This makes the frame 60 bytes excluding FCS.
- FCS (4 bytes):
  - CRC-32 uses polynomial 0x04C11DB7, reflected (LSB-first per byte), initial value 0xFFFFFFFF.
  - It covers the destination MAC through the last PAD byte. The preamble and SFD are excluded.
  - The output is the complemented register, least-significant byte first.
- IFG: `gmii_tx_en`=0 for `IFG_CYCLES` cycles, then the block returns to IDLE.
- A byte counter (7 bits) indexes the bytes within each state. The CRC updates byte-wise through combinational next-state logic that is registered each cycle while the covered bytes are driven.
- `arp_tx_en` while not in IDLE is ignored, unless the feature in Configuration is compiled in.
- Reset mid-frame: all outputs drop immediately, the FSM goes to IDLE and no `tx_done` is produced. The next frame starts cleanly without any IFG.

## Timing
- Reset values: `gmii_tx_en`=0, `gmii_txd`=8'h00, `tx_busy`=0, `tx_done`=0. The FSM is in IDLE and the CRC register is 0xFFFFFFFF.
- Latency: with the strobe sampled on edge N, the first 0x55 is on `gmii_txd`, with `gmii_tx_en`=1, after edge N+1.
- `gmii_tx_en` stays high for exactly 72 contiguous cycles (8 + 60 + 4).
- `tx_done` is high for 1 cycle, in the cycle immediately after the last FCS byte, concurrent with the first IFG cycle.
- `tx_busy` rises together with `gmii_tx_en`. It falls after the final IFG cycle.
- Minimum strobe-to-strobe spacing for back-to-back frames: 72 + `IFG_CYCLES` + 1 cycles.
- `gmii_txd` is 8'h00 whenever `gmii_tx_en`=0.

## Configuration
- Macro: `ARP_TX_PEND_EN`.
- Defined: a one-entry pending slot latches type, MAC and IP for any `arp_tx_en` seen while busy. A later strobe overwrites it, so the latest wins.
  - On IFG completion with the slot valid, the FSM goes directly to PREAMBLE. The IDLE cycle is skipped, so the next byte follows the last IFG cycle.
  - A strobe arriving in the same cycle as the IFG exit is captured into the pending slot and is not lost.
- Undefined: strobes while busy are dropped and no pending logic is synthesised.

## Test plan
- Request strobe, `des_ip`=0xC0A80102, after reset -> 72 cycles of `gmii_tx_en`. Bytes 8–13 are FF; bytes 28–29 are 00 01; bytes 40–45 are 00; bytes 46–49 are C0 A8 01 02. `tx_done` asserts at cycle 74 counted from the strobe.
- Reply strobe, `des_mac`=0xA0B1C2D3E4F5 -> destination MAC and target MAC are both A0 B1 C2 D3 E4 F5, and the opcode is 00 02.
- FCS check on any frame -> zlib-style CRC-32 of the 64 post-SFD bytes including FCS equals 0x2144DF1C.
- Second strobe 20 cycles into a frame:
  - Macro undefined -> exactly one frame is sent.
  - Macro defined -> a second frame starts exactly 12 cycles after the first frame's `gmii_tx_en` falls.
- Assert `sys_rst` at frame byte 30 -> `gmii_tx_en`=0 at once and no `tx_done`. A strobe after release gives a full, correct 72-byte frame.
